// File: rtl/ffs_pkg.sv
// Shared defaults and send-FSM state type for feature_frame_sender.
package ffs_pkg;

    localparam int FFS_N_FEAT      = 30;
    localparam int FFS_DW          = 10;
    localparam int FFS_TIMEOUT_CYC = 4096;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} ffs_state_e;

    function automatic int ffs_clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ffs_if.sv
// Serial feature-sample stream: valid/ready handshake with start-of-frame marker.
interface ffs_if #(parameter int DW = ffs_pkg::FFS_DW) ();

    logic          s_valid;
    logic          s_sof;
    logic [DW-1:0] s_data;
    logic          s_ready;

    modport master (output s_valid, output s_sof, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_sof, input  s_data, output s_ready);

endinterface

// File: rtl/ffs_bank.sv
// One N_FEAT x DW frame buffer: single indexed write port, full-vector read.
module ffs_bank
    import ffs_pkg::*;
#(
    parameter  int N_FEAT = FFS_N_FEAT,
    parameter  int DW     = FFS_DW,
    localparam int IW     = ffs_clog2_min1(N_FEAT)
) (
    input  logic                      Clock,
    input  logic                      Rst,
    input  logic                      we,
    input  logic [IW-1:0]             widx,
    input  logic [DW-1:0]             wdata,
    output logic [N_FEAT-1:0][DW-1:0] rdata
);

    logic [N_FEAT-1:0][DW-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[widx] = wdata;
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q;

endmodule

// File: rtl/feature_frame_sender.sv
// Ping-pong frame collector and Start/done sender for the drowsiness-detector ANN.
// Define FFS_OVF_CNT_EN to add the ovf_cnt port (cycles with s_valid while stalled).
module feature_frame_sender
    import ffs_pkg::*;
#(
    parameter int N_FEAT      = FFS_N_FEAT,
    parameter int DW          = FFS_DW,
    parameter int TIMEOUT_CYC = FFS_TIMEOUT_CYC
) (
    input  logic                      Clock,
    input  logic                      Rst,
    ffs_if.slave                      s,
    output logic [N_FEAT-1:0][DW-1:0] in1,
    output logic                      Start,
    input  logic                      done,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [15:0]               frames_sent
`ifdef FFS_OVF_CNT_EN
    ,
    output logic [15:0]               ovf_cnt
`endif
);

    localparam int            IW        = ffs_clog2_min1(N_FEAT);
    localparam int            TW        = ffs_clog2_min1(TIMEOUT_CYC);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_FEAT - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYC - 1);

    ffs_state_e    state_q, state_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          timeout_err_q, timeout_err_d;
    logic [15:0]   frames_sent_q, frames_sent_d;
    logic          done_q;

    logic          ready, accept, fill_done, release_bank;
    logic [IW-1:0] widx;
    logic [1:0]    bank_we;
    logic [N_FEAT-1:0][DW-1:0] bank_data [2];

    assign ready     = !bank_full_q[wr_bank_q];
    assign s.s_ready = ready;
    assign accept    = s.s_valid && ready;
    assign bank_we   = {accept && wr_bank_q, accept && !wr_bank_q};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ffs_bank #(.N_FEAT(N_FEAT), .DW(DW)) u_bank (
            .Clock (Clock),
            .Rst   (Rst),
            .we    (bank_we[b]),
            .widx  (widx),
            .wdata (s.s_data),
            .rdata (bank_data[b])
        );
    end

    assign in1 = bank_data[rd_bank_q];

    // s_sof restarts the frame at index 0 and takes priority over frame completion
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        fill_done = 1'b0;
        widx      = wr_idx_q;
        if (accept) begin
            if (s.s_sof) begin
                widx     = '0;
                wr_idx_d = IW'(1);
            end else if (wr_idx_q == LAST_IDX) begin
                fill_done = 1'b1;
                wr_bank_d = ~wr_bank_q;
                wr_idx_d  = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        timer_d       = timer_q;
        release_bank  = 1'b0;
        timeout_err_d = timeout_err_q;
        frames_sent_d = frames_sent_q;
        unique case (state_q)
            S_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d = S_START;
                    start_d = 1'b1;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done && !done_q) begin
                    release_bank  = 1'b1;
                    frames_sent_d = frames_sent_q + 16'd1;
                end else if (timer_q == LAST_TICK) begin
                    release_bank  = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (release_bank) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);

        // release and fill completion always hit different banks
        bank_full_d = bank_full_q;
        rd_bank_d   = rd_bank_q;
        if (release_bank) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
        if (fill_done) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_q       <= S_IDLE;
            bank_full_q   <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            timer_q       <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            frames_sent_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_full_q   <= bank_full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_idx_q      <= wr_idx_d;
            timer_q       <= timer_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            frames_sent_q <= frames_sent_d;
            done_q        <= done;
        end
    end

    assign Start       = start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign frames_sent = frames_sent_q;

`ifdef FFS_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (s.s_valid && !ready && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_feature_frame_sender.sv
// Bench for feature_frame_sender: frame-queue reference model plus directed and random traffic.
module tb_feature_frame_sender;
    import ffs_pkg::*;

    localparam int N    = 30;
    localparam int DW   = 10;
    localparam int TO   = 64;
    localparam int TO16 = 16;
    typedef logic [N-1:0][DW-1:0] frame_t;

    logic Clock = 1'b0;
    logic Rst   = 1'b0;
    logic done  = 1'b1;
    logic done16 = 1'b1;
    always #5 Clock = ~Clock;

    ffs_if #(.DW(DW)) sif ();
    ffs_if #(.DW(DW)) sif16 ();

    frame_t      in1, in1_16;
    logic        Start, Start16, busy, busy16, terr, terr16;
    logic [15:0] fs, fs16;
`ifdef FFS_OVF_CNT_EN
    logic [15:0] ovf, ovf16;
`endif

    feature_frame_sender #(.N_FEAT(N), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .Clock(Clock), .Rst(Rst), .s(sif), .in1(in1), .Start(Start), .done(done),
        .busy(busy), .timeout_err(terr), .frames_sent(fs)
`ifdef FFS_OVF_CNT_EN
        , .ovf_cnt(ovf)
`endif
    );

    feature_frame_sender #(.N_FEAT(N), .DW(DW), .TIMEOUT_CYC(TO16)) dut16 (
        .Clock(Clock), .Rst(Rst), .s(sif16), .in1(in1_16), .Start(Start16), .done(done16),
        .busy(busy16), .timeout_err(terr16), .frames_sent(fs16)
`ifdef FFS_OVF_CNT_EN
        , .ovf_cnt(ovf16)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int start_cnt = 0;
    int start_log[$];

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic void chkv(input string nm, input frame_t act, input frame_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic int log_at(input int i);
        if (i < start_log.size()) return start_log[i];
        return -1;
    endfunction

    // Reference model: completed frames queue FIFO (at most two held), one sender.
    frame_t m_q[$];
    int     m_cmp[$];
    frame_t m_fill;
    int     m_idx, m_s, m_sent, m_ovf;
    bit     m_snd, m_to, m_dprev, m_rdy, m_rel;

    always @(negedge Clock) begin
        if (!Rst) begin
            m_q.delete(); m_cmp.delete();
            m_fill = '0; m_idx = 0; m_snd = 0; m_sent = 0; m_to = 0; m_dprev = 0; m_ovf = 0;
            chk("rst_start", Start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_timeout_err", terr, 0);
            chk("rst_frames_sent", fs, 0);
            chkv("rst_in1", in1, '0);
        end else begin
            m_rdy = (m_q.size() < 2);
            chk("s_ready", sif.s_ready, m_rdy);
            chk("start", Start, m_snd && (cyc == m_s));
            chk("busy", busy, m_snd);
            chk("timeout_err", terr, m_to);
            chk("frames_sent", fs, m_sent & 16'hFFFF);
            if (m_snd) chkv("in1", in1, m_q[0]);
            if (Start) begin
                start_cnt++;
                start_log.push_back(int'(in1[0]));
            end
`ifdef FFS_OVF_CNT_EN
            chk("ovf_cnt", ovf, m_ovf);
            if (sif.s_valid && !m_rdy && m_ovf < 65535) m_ovf++;
`endif
            if (sif.s_valid && m_rdy) begin
                if (sif.s_sof) begin
                    m_fill[0] = sif.s_data;
                    m_idx = 1;
                end else begin
                    m_fill[m_idx] = sif.s_data;
                    if (m_idx == N - 1) begin
                        m_q.push_back(m_fill);
                        m_cmp.push_back(cyc);
                        m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            m_rel = 0;
            if (m_snd && cyc > m_s) begin
                if (done && !m_dprev) begin
                    m_rel = 1;
                    m_sent++;
                end else if (cyc == m_s + TO) begin
                    m_rel = 1;
                    m_to = 1;
                end
            end
            if (m_rel) begin
                m_snd = 0;
                void'(m_q.pop_front());
                void'(m_cmp.pop_front());
            end else if (!m_snd && m_q.size() > 0 && m_cmp[0] < cyc) begin
                m_snd = 1;
                m_s = cyc + 1;
            end
            m_dprev = done;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock); #1;
        end
    endtask

    task automatic do_reset();
        sif.s_valid = 0; sif.s_sof = 0;
        sif16.s_valid = 0; sif16.s_sof = 0;
        Rst = 0;
        step(2);
        Rst = 1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic sof);
        bit acc;
        int n;
        acc = 0; n = 0;
        sif.s_valid = 1; sif.s_data = d; sif.s_sof = sof;
        while (!acc && n < 500) begin
            @(negedge Clock);
            acc = sif.s_ready;
            if (acc) acc_cyc = cyc;
            @(posedge Clock); #1;
            n++;
        end
        chk("push_accept", acc, 1);
        sif.s_valid = 0; sif.s_sof = 0;
    endtask

    task automatic wait_start(output int sc, output frame_t sv);
        bit ok;
        int n;
        ok = 0; n = 0; sc = -1; sv = '0;
        while (!ok && n < 400) begin
            @(negedge Clock);
            if (Start) begin ok = 1; sc = cyc; sv = in1; end
            n++;
        end
        chk("start_seen", ok, 1);
        @(posedge Clock); #1;
    endtask

    task automatic wait_start16(output int sc, output frame_t sv);
        bit ok;
        int n;
        ok = 0; n = 0; sc = -1; sv = '0;
        while (!ok && n < 400) begin
            @(negedge Clock);
            if (Start16) begin ok = 1; sc = cyc; sv = in1_16; end
            n++;
        end
        chk("start16_seen", ok, 1);
    endtask

    // called one cycle after Start: done low, then high in cycle Start+dly
    task automatic ack(input int dly);
        done = 0;
        step(dly - 1);
        done = 1;
        step(1);
    endtask

    initial begin
        int     sc, last, n0;
        frame_t sv;
        sif.s_valid = 0; sif.s_sof = 0; sif.s_data = '0;
        sif16.s_valid = 0; sif16.s_sof = 0; sif16.s_data = '0;
        Rst = 0;
        step(3);
        Rst = 1;

        // 1: one clean frame, latency and ack
        for (int k = 0; k < N; k++) push(DW'(k + 1), 0);
        last = acc_cyc;
        wait_start(sc, sv);
        chk("t1_latency", sc - last, 2);
        chk("t1_in1_0", sv[0], 1);
        chk("t1_in1_29", sv[29], 30);
        ack(5);
        @(negedge Clock);
        chk("t1_frames_sent", fs, 1);
        chk("t1_busy", busy, 0);
        step(1);

        // 2: both banks full, stall, then release
        done = 0;
        n0 = start_log.size();
        for (int k = 0; k < 2 * N; k++) push(DW'(31 + k), 0);
        sif.s_valid = 1; sif.s_data = DW'(91); sif.s_sof = 0;
        @(negedge Clock);
        chk("t2_ready_low_a", sif.s_ready, 0);
        step(1);
        @(negedge Clock);
        chk("t2_ready_low_b", sif.s_ready, 0);
        step(1);
        chk("t2_first_start_in1_0", log_at(n0), 31);
        done = 1;
        push(DW'(91), 0);
        wait_start(sc, sv);
        chk("t2_second_in1_0", sv[0], 61);
        ack(3);

        // 3: stale partial frame dropped by s_sof
        for (int k = 0; k < 12; k++) push(DW'(900 + k), 0);
        push(DW'(500), 1);
        for (int k = 1; k < N; k++) push(DW'(500 + k), 0);
        wait_start(sc, sv);
        chk("t3_in1_0", sv[0], 500);
        chk("t3_in1_12", sv[12], 512);
        chk("t3_in1_29", sv[29], 529);
        ack(4);

        // 5: reset mid-fill and mid-wait
        for (int k = 0; k < 17; k++) push(DW'(200 + k), 0);
        do_reset();
        n0 = start_cnt;
        for (int k = 0; k < 13; k++) push(DW'(300 + k), 0);
        step(20);
        chk("t5_no_start_partial", start_cnt - n0, 0);
        for (int k = 13; k < N; k++) push(DW'(300 + k), 0);
        wait_start(sc, sv);
        chk("t5_in1_0", sv[0], 300);
        chk("t5_in1_29", sv[29], 329);
        step(2);
        do_reset();
        n0 = start_cnt;
        step(10);
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_no_start_after_rst", start_cnt - n0, 0);

        // 4: timeout on the 16-cycle instance
        do_reset();
        @(negedge Clock);
        chk("t4_ready16", sif16.s_ready, 1);
        step(1);
        for (int k = 0; k < N; k++) begin
            sif16.s_valid = 1; sif16.s_data = DW'(k + 1);
            step(1);
        end
        sif16.s_valid = 0;
        wait_start16(sc, sv);
        chk("t4_in1_0", sv[0], 1);
        repeat (TO16) @(negedge Clock);
        chk("t4_terr_before", terr16, 0);
        @(negedge Clock);
        chk("t4_terr", terr16, 1);
        chk("t4_frames_sent", fs16, 0);
        chk("t4_busy", busy16, 0);
        step(1);
        for (int k = 0; k < N; k++) begin
            sif16.s_valid = 1; sif16.s_data = DW'(101 + k);
            step(1);
        end
        sif16.s_valid = 0;
        wait_start16(sc, sv);
        chk("t4_next_in1_0", sv[0], 101);
        chk("t4_terr_sticky", terr16, 1);
        step(1);

`ifdef FFS_OVF_CNT_EN
        // 6: overflow counter with both banks full
        do_reset();
        done = 0;
        for (int k = 0; k < 2 * N; k++) push(DW'(k), 0);
        sif.s_valid = 1; sif.s_data = DW'(7);
        step(7);
        sif.s_valid = 0;
        @(negedge Clock);
        chk("t6_ovf_cnt", ovf, 7);
        chk("t6_ovf16", ovf16, 0);
        step(1);
        done = 1;
        step(2);
`endif

        // random traffic, alternating busy and sluggish done activity
        for (int i = 0; i < 4000; i++) begin
            sif.s_valid = ($urandom_range(0, 3) != 0);
            sif.s_data  = DW'($urandom_range(0, 1023));
            sif.s_sof   = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, ((i / 500) % 2 == 1) ? 150 : 4) == 0) done = ~done;
            step(1);
        end
        sif.s_valid = 0; sif.s_sof = 0;
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
